// File: rtl/instr_loader.sv
// Instruction loader: parses a byte stream (16-bit big-endian word count,
// then 32-bit big-endian words), writes each word into the processor's
// instruction memory and holds the processor in reset until the program
// is complete.
module instr_loader #(
  parameter int MAX_WORDS    = 1024,
  parameter int CPU_RST_HOLD = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  input  logic        reload,
  output logic        byte_ready,
  output logic        instr_we,
  output logic [31:0] instr_feed,
  output logic [9:0]  instr_write_address,
  output logic        cpu_rst,
  output logic [9:0]  init_pc,
  output logic        done,
  output logic        error
);

  localparam logic [2:0] HDR_HI  = 3'd0;
  localparam logic [2:0] HDR_LO  = 3'd1;
  localparam logic [2:0] LOAD    = 3'd2;
  localparam logic [2:0] RELEASE = 3'd3;
  localparam logic [2:0] RUN     = 3'd4;
  localparam logic [2:0] ERROR   = 3'd5;

  localparam logic [15:0] MAX_N  = 16'(MAX_WORDS);
  localparam logic [15:0] HOLD_N = 16'(CPU_RST_HOLD);

  logic [2:0]  state;
  logic [15:0] count;
  logic [9:0]  word_idx;
  logic [1:0]  phase;
  logic [23:0] shift;
  logic [15:0] hold_cnt;
  logic        accept;
  logic [15:0] hdr_n;

  assign accept  = byte_valid && byte_ready;
  assign hdr_n   = {count[15:8], byte_data};
  assign init_pc = '0;

  // Status outputs are pure functions of the current state.
  always_comb begin
    byte_ready = (state == HDR_HI) || (state == HDR_LO) || (state == LOAD);
    cpu_rst    = (state != RUN);
    done       = (state == RUN);
    error      = (state == ERROR);
  end

  // Stream parser, word assembly, write strobe and release sequencing.
  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= HDR_HI;
      count               <= '0;
      word_idx            <= '0;
      phase               <= '0;
      shift               <= '0;
      hold_cnt            <= '0;
      instr_we            <= 1'b0;
      instr_feed          <= '0;
      instr_write_address <= '0;
    end else begin
      instr_we <= 1'b0;
      case (state)
        HDR_HI: begin
          if (accept) begin
            count[15:8] <= byte_data;
            state       <= HDR_LO;
          end
        end
        HDR_LO: begin
          if (accept) begin
            count[7:0] <= byte_data;
            hold_cnt   <= '0;
            phase      <= '0;
            word_idx   <= '0;
            if (hdr_n == 16'd0)
              state <= RELEASE;
            else if (hdr_n > MAX_N)
              state <= ERROR;
            else
              state <= LOAD;
          end
        end
        LOAD: begin
          if (accept) begin
            shift <= {shift[15:0], byte_data};
            phase <= phase + 2'd1;
            if (phase == 2'd3) begin
              instr_we            <= 1'b1;
              instr_feed          <= {shift, byte_data};
              instr_write_address <= word_idx;
              word_idx            <= word_idx + 10'd1;
              if ({6'd0, word_idx} == count - 16'd1) begin
                hold_cnt <= '0;
                state    <= RELEASE;
              end
            end
          end
        end
        RELEASE: begin
          if (hold_cnt == HOLD_N)
            state <= RUN;
          else
            hold_cnt <= hold_cnt + 16'd1;
        end
        RUN, ERROR: begin
          if (reload) begin
            state    <= HDR_HI;
            count    <= '0;
            word_idx <= '0;
            phase    <= '0;
            hold_cnt <= '0;
          end
        end
        default: state <= HDR_HI;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_loader.sv
// Testbench for instr_loader: directed and randomized byte streams checked
// against a stream-level reference model of the expected writes and timing.
module tb_instr_loader;

  typedef logic [7:0] bq_t [$];

  localparam int HOLD = 2;
  localparam int MAXW = 1024;

  logic        clk = 1'b0;
  logic        rst;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        reload;
  logic        byte_ready;
  logic        instr_we;
  logic [31:0] instr_feed;
  logic [9:0]  instr_write_address;
  logic        cpu_rst;
  logic [9:0]  init_pc;
  logic        done;
  logic        error;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;
  int rel_cyc = -1;
  logic prev_rst = 1'b1;

  logic [9:0]  wr_addr [$];
  logic [31:0] wr_data [$];
  int          wr_cyc  [$];
  int          acc_cyc [$];

  instr_loader #(.MAX_WORDS(MAXW), .CPU_RST_HOLD(HOLD)) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .reload(reload), .byte_ready(byte_ready), .instr_we(instr_we),
    .instr_feed(instr_feed), .instr_write_address(instr_write_address),
    .cpu_rst(cpu_rst), .init_pc(init_pc), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every write and the cycle in which the processor is released.
  always @(negedge clk) begin
    if (instr_we === 1'b1) begin
      wr_addr.push_back(instr_write_address);
      wr_data.push_back(instr_feed);
      wr_cyc.push_back(cyc);
    end
    if (prev_rst === 1'b1 && cpu_rst === 1'b0) rel_cyc = cyc;
    prev_rst = cpu_rst;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic bq_t make_stream(input int n);
    bq_t q;
    q.push_back(8'(n / 256));
    q.push_back(8'(n % 256));
    for (int i = 0; i < 4 * n; i++) q.push_back(8'($urandom));
    return q;
  endfunction

  function automatic int model_n(input bq_t q);
    return int'(q[0]) * 256 + int'(q[1]);
  endfunction

  function automatic logic [31:0] model_word(input bq_t q, input int k);
    return 32'(q[2+4*k]) * 32'h0100_0000 + 32'(q[3+4*k]) * 32'h0001_0000 +
           32'(q[4+4*k]) * 32'h0000_0100 + 32'(q[5+4*k]);
  endfunction

  task automatic clear_log();
    wr_addr.delete(); wr_data.delete(); wr_cyc.delete(); acc_cyc.delete();
    rel_cyc = -1;
  endtask

  task automatic send(input bq_t q, input int gap);
    foreach (q[i]) begin
      while ($urandom_range(99) < gap) begin
        byte_valid = 1'b0;
        byte_data  = 8'($urandom);
        @(negedge clk);
      end
      byte_valid = 1'b1;
      byte_data  = q[i];
      chk("ready_during_send", 32'(byte_ready), 32'd1);
      if (byte_ready === 1'b1) acc_cyc.push_back(cyc + 1);
      @(negedge clk);
    end
    byte_valid = 1'b0;
  endtask

  task automatic pulse_reload();
    reload = 1'b1;
    @(negedge clk);
    reload = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_we"},    32'(instr_we), 32'd0);
    chk({tag, "_feed"},  instr_feed, 32'd0);
    chk({tag, "_addr"},  32'(instr_write_address), 32'd0);
    chk({tag, "_cpurst"}, 32'(cpu_rst), 32'd1);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_error"}, 32'(error), 32'd0);
    chk({tag, "_ready"}, 32'(byte_ready), 32'd1);
    chk({tag, "_pc"},    32'(init_pc), 32'd0);
  endtask

  task automatic finish_load(input string tag, input bq_t q);
    int n;
    int expw;
    bit err;
    n    = model_n(q);
    err  = (n > MAXW);
    expw = err ? 0 : n;
    for (int i = 0; i < 64 && done !== 1'b1 && error !== 1'b1; i++) @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk({tag, "_wr_count"}, 32'(wr_addr.size()), 32'(expw));
    for (int k = 0; k < wr_addr.size() && k < expw; k++) begin
      chk({tag, "_wr_addr"}, 32'(wr_addr[k]), 32'(k));
      chk({tag, "_wr_data"}, wr_data[k], model_word(q, k));
      if (acc_cyc.size() > 5 + 4 * k)
        chk({tag, "_wr_cycle"}, 32'(wr_cyc[k]), 32'(acc_cyc[5+4*k]));
    end
    chk({tag, "_we_idle"}, 32'(instr_we), 32'd0);
    chk({tag, "_ready"}, 32'(byte_ready), 32'd0);
    if (err) begin
      chk({tag, "_error"},  32'(error), 32'd1);
      chk({tag, "_done"},   32'(done), 32'd0);
      chk({tag, "_cpurst"}, 32'(cpu_rst), 32'd1);
    end else begin
      chk({tag, "_done"},   32'(done), 32'd1);
      chk({tag, "_cpurst"}, 32'(cpu_rst), 32'd0);
      chk({tag, "_error"},  32'(error), 32'd0);
      if (acc_cyc.size() > 0)
        chk({tag, "_release_delay"}, 32'(rel_cyc - acc_cyc[acc_cyc.size()-1]), 32'(HOLD + 1));
      if (n > 0) begin
        chk({tag, "_feed_hold"}, instr_feed, model_word(q, n - 1));
        chk({tag, "_addr_hold"}, 32'(instr_write_address), 32'(n - 1));
      end
    end
  endtask

  initial begin
    bq_t q, a, b;
    int n;
    rst = 1'b1; byte_valid = 1'b0; byte_data = '0; reload = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("reset");
    clear_log();

    // Reference two-word program, back-to-back bytes.
    q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    send(q, 0);
    finish_load("ref", q);

    // Reload from RUN, then a one-word program.
    pulse_reload();
    chk("reload_cpurst", 32'(cpu_rst), 32'd1);
    chk("reload_done", 32'(done), 32'd0);
    chk("reload_ready", 32'(byte_ready), 32'd1);
    clear_log();
    q = make_stream(1);
    send(q, 0);
    finish_load("reload1", q);

    // Reference program with random valid gaps.
    pulse_reload();
    clear_log();
    q = '{8'h00, 8'h02, 8'h20, 8'h08, 8'h00, 8'h05, 8'h01, 8'h09, 8'h50, 8'h20};
    send(q, 50);
    finish_load("gaps", q);

    // Empty program.
    pulse_reload();
    clear_log();
    q = '{8'h00, 8'h00};
    send(q, 0);
    finish_load("empty", q);

    // Oversized header, error persists until reload.
    pulse_reload();
    clear_log();
    q = '{8'h04, 8'h01};
    send(q, 0);
    finish_load("oversize", q);
    for (int i = 0; i < 5; i++) begin
      byte_valid = 1'b1;
      byte_data  = 8'($urandom);
      @(negedge clk);
    end
    byte_valid = 1'b0;
    chk("err_persist", 32'(error), 32'd1);
    chk("err_no_write", 32'(wr_addr.size()), 32'd0);
    pulse_reload();
    chk("err_clear_error", 32'(error), 32'd0);
    chk("err_clear_ready", 32'(byte_ready), 32'd1);
    chk("err_clear_cpurst", 32'(cpu_rst), 32'd1);

    // Reload pulse while parsing the header is ignored.
    clear_log();
    q = make_stream(2);
    a = '{q[0]};
    b = q[1:$];
    send(a, 0);
    pulse_reload();
    send(b, 20);
    finish_load("reload_ignored", q);

    // Reset in the middle of the second word.
    pulse_reload();
    clear_log();
    q = make_stream(2);
    a = q[0:7];
    send(a, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_vals("midrst");
    chk("midrst_wr_count", 32'(wr_addr.size()), 32'd1);
    if (wr_addr.size() > 0) begin
      chk("midrst_wr_addr", 32'(wr_addr[0]), 32'd0);
      chk("midrst_wr_data", wr_data[0], model_word(q, 0));
    end
    clear_log();
    q = make_stream(1);
    send(q, 0);
    finish_load("after_rst", q);

    // Randomized short programs.
    for (int t = 0; t < 4; t++) begin
      pulse_reload();
      clear_log();
      n = $urandom_range(1, 6);
      q = make_stream(n);
      send(q, 30);
      finish_load("random", q);
    end

    // Largest accepted program.
    pulse_reload();
    clear_log();
    q = make_stream(MAXW);
    send(q, 0);
    finish_load("max_len", q);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 Parameter: MAX_WORDS, default 1024, maximum accepted program length in words (at most 1024, the 10-bit address space).
REQ-002 Parameter: CPU_RST_HOLD, default 2, cycles the processor reset is held after the final write.
REQ-003 clk  in  1  single clock; all state updates on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 byte_valid  in  1  upstream byte stream valid.
REQ-006 byte_data  in  8  upstream byte.
REQ-007 reload  in  1  single-cycle request to accept a new program.
REQ-008 byte_ready  out  1  loader can accept a byte this cycle.
REQ-009 instr_we  out  1  instruction-memory write strobe to the processor.
REQ-010 instr_feed  out  32  instruction word to be written.
REQ-011 instr_write_address  out  10  word address of the write.
REQ-012 cpu_rst  out  1  reset driven to the processor's rst input.
REQ-013 init_pc  out  10  processor start PC; constant 10'd0.
REQ-014 done  out  1  program loaded and processor released.
REQ-015 error  out  1  header length exceeded MAX_WORDS.

Function
REQ-016 A byte SHALL be accepted on a rising edge where byte_valid=1 and byte_ready=1; otherwise it is not consumed.
REQ-017 Stream format SHALL be a 2-byte big-endian word count N, then N words of 4 bytes each, most significant byte first.
REQ-018 States SHALL be HDR_HI, HDR_LO, LOAD, RELEASE, RUN, and ERROR; byte_ready SHALL be 1 only in HDR_HI, HDR_LO and LOAD.
REQ-019 HDR_HI SHALL move to HDR_LO on acceptance, latching count[15:8].
REQ-020 HDR_LO SHALL latch count[7:0] on acceptance, then go to LOAD if 1<=N<=MAX_WORDS, to RELEASE if N=0, or to ERROR if N>MAX_WORDS.
REQ-021 LOAD SHALL assemble bytes into a 32-bit shift register; on acceptance of the 4th byte of word k, instr_we SHALL be 1 for exactly the following cycle, with instr_feed=word and instr_write_address=k.
REQ-022 instr_feed and instr_write_address SHALL hold their last values while instr_we=0.
REQ-023 The word index SHALL start at 0 and increment by 1 per completed word; on acceptance of the last byte of word N-1, the state SHALL go to RELEASE.
REQ-024 cpu_rst SHALL be 1 in every state except RUN.
REQ-025 RELEASE SHALL last CPU_RST_HOLD+1 cycles, counted from the edge that entered it, then go to RUN; in RUN, cpu_rst=0 and done=1.
REQ-026 ERROR SHALL drive error=1 and cpu_rst=1 and SHALL perform no writes; it persists until rst or reload.
REQ-027 reload=1 in RUN or ERROR SHALL go to HDR_HI on the next edge, clearing done, error and the word index, and raising cpu_rst in the same edge.
REQ-028 reload SHALL be ignored in HDR_HI, HDR_LO, LOAD and RELEASE.
REQ-029 A partially received word SHALL never be written.
REQ-030 byte_valid when byte_ready=0 SHALL be ignored and SHALL have no effect on state.

Reset
REQ-031 rst=1 SHALL on that edge force state HDR_HI, instr_we=0, instr_feed=0, instr_write_address=0, cpu_rst=1, done=0, error=0, and clear the count, word index, byte phase and hold counter.
REQ-032 rst SHALL take priority over reload and byte acceptance.
REQ-033 rst mid-LOAD SHALL abort the load; words already written SHALL remain in processor memory, and the next load SHALL restart at address 0.

Verification
REQ-034 Bytes 00 02 | 20 08 00 05 | 01 09 50 20, one per cycle, CPU_RST_HOLD=2 -> two instr_we pulses, (addr 0, 0x20080005) then (addr 1, 0x01095020); cpu_rst low and done=1 exactly 3 cycles after the final write cycle.
REQ-035 Same stream with byte_valid deasserted randomly between bytes -> identical writes; no write issued while a word is incomplete.
REQ-036 Header 00 00 -> no instr_we; RUN reached 3 cycles after the header-low edge; done=1.
REQ-037 Header 04 01 (N=1025) -> error=1, byte_ready=0, cpu_rst=1 held; then a reload pulse -> error=0, HDR_HI, byte_ready=1.
REQ-038 rst asserted after 6 of 8 payload bytes of a 2-word load -> one write (addr 0) only; outputs return to reset values; a fresh 1-word load then writes addr 0.
REQ-039 In RUN, a reload pulse followed by a 1-word stream -> cpu_rst=1 from the reload edge, write at addr 0, re-release after the hold.
